// File: rtl/fw_config_regs_if.sv
// Avalon-MM slave bus bundle for the firmware configuration register block.
// The bus master drives address, data and strobes; the slave returns readdata.
interface fw_config_regs_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic              write_n;
  logic              read_n;
  logic [31:0]       readdata;

  modport master (output address, output writedata, output write_n, output read_n, input readdata);
  modport slave  (input address, input writedata, input write_n, input read_n, output readdata);
endinterface

// File: rtl/fw_config_regs.sv
// Password-protected configuration register block with auto-relock and brute-force lockout.
// Reads are registered (latency 1); user registers are also exported as a flat bus.
module fw_config_regs #(
  parameter logic [7:0]  VERSION_MAJOR  = 8'd2,
  parameter logic [7:0]  VERSION_MINOR  = 8'd0,
  parameter logic [7:0]  PRODUCT_ID     = 8'd0,
  parameter logic [31:0] LOCK_PWD       = 32'd12345,
  parameter int          NUM_USER       = 6,
  parameter int          ADDR_W         = 7,
  parameter logic [31:0] RELOCK_CYCLES  = 32'd50_000_000,
  parameter int          MAX_FAIL       = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd1_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  fw_config_regs_if.slave         bus,
  output logic [32*NUM_USER-1:0]  user_regs,
  output logic                    unlocked
);

  typedef enum logic [1:0] {LOCKED, UNLOCKED, LOCKOUT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   timer, timer_nxt;
  logic [3:0]    fail_cnt, fail_nxt, fail_inc;
  logic          reject;
  logic [31:0]   user_q [NUM_USER];
  logic [31:0]   read_val;
  logic [NUM_USER-1:0] user_sel;
  logic          wr, rd, lock_wr, user_wr, status_rd;

  assign wr        = !bus.write_n;
  assign rd        = !bus.read_n;
  assign lock_wr   = wr && (bus.address == ADDR_W'(1));
  assign status_rd = rd && (bus.address == ADDR_W'(2));
  assign user_wr   = wr && (|user_sel);
  assign unlocked  = (state == UNLOCKED);

  always_comb begin
    user_sel = '0;
    for (int i = 0; i < NUM_USER; i++) begin
      user_sel[i] = (bus.address == ADDR_W'(i + 4));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOCKED;
      timer    <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      fail_cnt <= fail_nxt;
    end
  end

  // A user write in UNLOCKED reloads the timer and takes priority over relock expiry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fail_nxt  = fail_cnt;
    fail_inc  = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
    case (state)
      LOCKED: begin
        if (lock_wr) begin
          if (bus.writedata == LOCK_PWD) begin
            state_nxt = UNLOCKED;
            fail_nxt  = '0;
            timer_nxt = RELOCK_CYCLES;
          end else if (bus.writedata != '0) begin
            fail_nxt = fail_inc;
            if ((MAX_FAIL != 0) && (int'(fail_inc) == MAX_FAIL)) begin
              state_nxt = LOCKOUT;
              timer_nxt = LOCKOUT_CYCLES;
            end
          end
        end
      end
      UNLOCKED: begin
        if (lock_wr) begin
          if (bus.writedata == LOCK_PWD) begin
            timer_nxt = RELOCK_CYCLES;
          end else begin
            state_nxt = LOCKED;
            timer_nxt = '0;
          end
        end else if (user_wr) begin
          timer_nxt = RELOCK_CYCLES;
        end else if (RELOCK_CYCLES != '0) begin
          if (timer <= 32'd1) begin
            state_nxt = LOCKED;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer - 32'd1;
          end
        end
      end
      LOCKOUT: begin
        if (timer <= 32'd1) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
          fail_nxt  = '0;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      default: begin
        state_nxt = LOCKED;
        timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    read_val = '0;
    if (bus.address == ADDR_W'(0)) begin
      read_val = {8'(NUM_USER), PRODUCT_ID, VERSION_MAJOR, VERSION_MINOR};
    end else if (bus.address == ADDR_W'(2)) begin
      read_val = {24'b0, fail_cnt, 1'b0, reject, (state == LOCKOUT), (state == UNLOCKED)};
    end else if (bus.address == ADDR_W'(3)) begin
      read_val = timer;
    end else begin
      for (int i = 0; i < NUM_USER; i++) begin
        if (user_sel[i]) begin
          read_val = user_q[i];
        end
      end
    end
  end

  // Reject flag: a set on the same edge as a STATUS read clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject       <= 1'b0;
      bus.readdata <= '0;
      for (int i = 0; i < NUM_USER; i++) begin
        user_q[i] <= '0;
      end
    end else begin
      if (user_wr && (state != UNLOCKED)) begin
        reject <= 1'b1;
      end else if (status_rd) begin
        reject <= 1'b0;
      end
      if (rd) begin
        bus.readdata <= read_val;
      end
      for (int i = 0; i < NUM_USER; i++) begin
        if (wr && user_sel[i] && (state == UNLOCKED)) begin
          user_q[i] <= bus.writedata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_USER; g++) begin : g_export
    assign user_regs[32*g +: 32] = user_q[g];
  end

endmodule

// File: tb/tb_fw_config_regs.sv
// Scoreboard bench for fw_config_regs: directed scenarios followed by randomized traffic,
// compared against a behavioural model of the lock/lockout rules.
module tb_fw_config_regs;
  localparam int          NUM_USER = 6;
  localparam int          ADDR_W   = 7;
  localparam logic [31:0] PWD      = 32'd12345;
  localparam int          RELOCK   = 8;
  localparam int          LOCKOUT  = 16;
  localparam int          MAXF     = 3;
  localparam int          M_LOCKED = 0;
  localparam int          M_UNL    = 1;
  localparam int          M_LO     = 2;

  logic clk;
  logic reset;
  logic [32*NUM_USER-1:0] user_regs;
  logic unlocked;

  fw_config_regs_if #(.ADDR_W(ADDR_W)) bus ();

  fw_config_regs #(
    .VERSION_MAJOR(8'd2), .VERSION_MINOR(8'd0), .PRODUCT_ID(8'd0),
    .LOCK_PWD(PWD), .NUM_USER(NUM_USER), .ADDR_W(ADDR_W),
    .RELOCK_CYCLES(32'(RELOCK)), .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(32'(LOCKOUT))
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .user_regs(user_regs), .unlocked(unlocked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int          m_mode, m_timer, m_fail;
  bit          m_rej;
  logic [31:0] m_user [NUM_USER];
  logic [31:0] exp_q [$];
  int          passed, total;
  bit          fired;

  function automatic bit is_user(int a);
    return (a >= 4) && (a < 4 + NUM_USER);
  endfunction

  function automatic logic [31:0] model_read(int a);
    if (a == 0) return 32'h0600_0200;
    if (a == 2) return {24'b0, 4'(m_fail), 1'b0, m_rej, m_mode == M_LO, m_mode == M_UNL};
    if (a == 3) return 32'(m_timer);
    if (is_user(a)) return m_user[a-4];
    return 32'h0;
  endfunction

  function automatic logic [191:0] model_packed();
    logic [191:0] p;
    for (int i = 0; i < NUM_USER; i++) p[32*i +: 32] = m_user[i];
    return p;
  endfunction

  task automatic model_reset();
    m_mode = M_LOCKED; m_timer = 0; m_fail = 0; m_rej = 0;
    for (int i = 0; i < NUM_USER; i++) m_user[i] = 32'h0;
  endtask

  task automatic model_step(bit we, bit re, int a, logic [31:0] d);
    bit set_rej, clr_rej;
    set_rej = we && is_user(a) && (m_mode != M_UNL);
    clr_rej = re && (a == 2);
    if (m_mode == M_LOCKED) begin
      if (we && a == 1 && d == PWD) begin
        m_mode = M_UNL; m_fail = 0; m_timer = RELOCK;
      end else if (we && a == 1 && d != 0) begin
        m_fail = (m_fail + 1 > 15) ? 15 : m_fail + 1;
        if (m_fail == MAXF) begin m_mode = M_LO; m_timer = LOCKOUT; end
      end
    end else if (m_mode == M_UNL) begin
      if (we && is_user(a)) m_user[a-4] = d;
      if (we && a == 1) begin
        if (d == PWD) m_timer = RELOCK;
        else begin m_mode = M_LOCKED; m_timer = 0; end
      end else if (we && is_user(a)) begin
        m_timer = RELOCK;
      end else begin
        m_timer = m_timer - 1;
        if (m_timer == 0) m_mode = M_LOCKED;
      end
    end else begin
      m_timer = m_timer - 1;
      if (m_timer == 0) begin m_mode = M_LOCKED; m_fail = 0; end
    end
    if (set_rej) m_rej = 1;
    else if (clr_rej) m_rej = 0;
  endtask

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One bus cycle: drive, predict the read, let the edge happen, advance the model.
  task automatic applyStimulus(bit we, bit re, int a, logic [31:0] d);
    bus.write_n   = !we;
    bus.read_n    = !re;
    bus.address   = ADDR_W'(a);
    bus.writedata = d;
    if (re) exp_q.push_back(model_read(a));
    @(posedge clk);
    model_step(we, re, a, d);
    #1;
    bus.write_n = 1'b1;
    bus.read_n  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: pops expected read data after each read edge and tracks exported state.
  initial begin
    forever begin
      @(posedge clk);
      fired = !bus.read_n && !reset;
      @(negedge clk);
      if (fired) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("[TB] FAIL readdata_unexpected: got %h expected no read", bus.readdata);
        end else begin
          checkOutput("readdata", 192'(bus.readdata), 192'(exp_q.pop_front()));
        end
      end
      checkOutput("unlocked", 192'(unlocked), 192'(m_mode == M_UNL));
      checkOutput("user_regs", user_regs, model_packed());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int a, op;
    passed = 0; total = 0;
    model_reset();
    bus.write_n = 1'b1; bus.read_n = 1'b1; bus.address = '0; bus.writedata = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 2, 0);
    for (int i = 0; i < NUM_USER; i++) applyStimulus(0, 1, 4 + i, 0);

    applyStimulus(1, 0, 4, 32'hA5A5A5A5);
    applyStimulus(0, 1, 4, 0);
    applyStimulus(0, 1, 2, 0);
    applyStimulus(0, 1, 2, 0);

    applyStimulus(1, 0, 1, PWD);
    applyStimulus(1, 0, 6, 32'hDEADBEEF);
    repeat (10) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 7, 32'h1234);
    applyStimulus(0, 1, 2, 0);

    repeat (3) applyStimulus(1, 0, 1, 1);
    applyStimulus(0, 1, 2, 0);
    applyStimulus(1, 0, 1, PWD);
    repeat (16) applyStimulus(0, 1, 3, 0);
    applyStimulus(0, 1, 2, 0);
    applyStimulus(1, 0, 1, PWD);
    applyStimulus(0, 1, 2, 0);

    applyStimulus(1, 0, 5, 32'h11);
    repeat (3) applyStimulus(0, 0, 0, 0);
    do_reset();
    applyStimulus(0, 1, 3, 0);

    applyStimulus(1, 0, 1, PWD);
    applyStimulus(1, 0, 5, 5);
    applyStimulus(0, 1, 10, 0);
    applyStimulus(1, 1, 5, 7);
    applyStimulus(0, 1, 5, 0);

    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 99));
      a  = int'($urandom_range(0, 11));
      if (op < 25) a = 1;
      case ($urandom_range(0, 3))
        0: d = PWD;
        1: d = 32'h0;
        2: d = 32'h1;
        default: d = $urandom;
      endcase
      if (op == 99) do_reset();
      else if (op >= 90) repeat ($urandom_range(1, 12)) applyStimulus(0, 0, 0, 0);
      else applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, a, d);
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 192'(exp_q.size()), 192'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
